// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: register file geometry and the index/word types
// used by the register file, decoder and register access controller.
package lc2k_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t REG_ZERO = 3'd0;

    function automatic logic is_zero_reg(input reg_idx_t idx);
        return idx == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register.
// A set and a clear of the same index in one cycle leaves the bit set.
module reg_scoreboard
    import lc2k_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  reg_idx_t            set_idx,
    input  logic                clr_en,
    input  reg_idx_t            clr_idx,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/reg_access_ctrl.sv
// LC2K register access controller: issues decoded instructions, reads operands,
// forwards writebacks to the register file and stalls on RAW/WAW hazards.
module reg_access_ctrl
    import lc2k_pkg::*;
#(
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iss_valid,
    output logic               iss_ready,
    input  reg_idx_t           iss_regA,
    input  reg_idx_t           iss_regB,
    input  reg_idx_t           iss_dest,
    input  logic               iss_dest_en,
    output reg_idx_t           rf_read_regA,
    output reg_idx_t           rf_read_regB,
    input  word_t              rf_valA,
    input  word_t              rf_valB,
    output reg_idx_t           rf_write_reg,
    output word_t              rf_write_value,
    output logic               rf_write_en,
    input  logic               wb_valid,
    input  reg_idx_t           wb_reg,
    input  word_t              wb_value,
    output logic               op_valid,
    input  logic               op_ready,
    output word_t              op_valA,
    output word_t              op_valB,
    output reg_idx_t           op_dest,
    output logic               op_dest_en,
    output logic               wb_err,
    output logic [STALL_W-1:0] stall_cnt
);

    logic [NUM_REGS-1:0] busy;
    logic                wb_hit_a, wb_hit_b, wb_hit_d;
    logic                raw_a, raw_b, waw;
    logic                issue, sb_set, sb_clr;

    logic               op_valid_q, op_valid_d;
    word_t              op_val_a_q, op_val_a_d;
    word_t              op_val_b_q, op_val_b_d;
    reg_idx_t           op_dest_q, op_dest_d;
    logic               op_dest_en_q, op_dest_en_d;
    logic               wb_err_q, wb_err_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    assign rf_read_regA   = iss_regA;
    assign rf_read_regB   = iss_regB;
    assign rf_write_reg   = wb_reg;
    assign rf_write_value = wb_value;
    assign rf_write_en    = sb_clr;

    // A writeback landing this cycle resolves the hazard on its register.
    assign wb_hit_a = wb_valid && (wb_reg == iss_regA);
    assign wb_hit_b = wb_valid && (wb_reg == iss_regB);
    assign wb_hit_d = wb_valid && (wb_reg == iss_dest);

    assign raw_a = !is_zero_reg(iss_regA) && busy[iss_regA] && !wb_hit_a;
    assign raw_b = !is_zero_reg(iss_regB) && busy[iss_regB] && !wb_hit_b;
    assign waw   = iss_dest_en && !is_zero_reg(iss_dest) && busy[iss_dest] && !wb_hit_d;

    assign iss_ready = !raw_a && !raw_b && !waw && (!op_valid_q || op_ready);
    assign issue     = iss_valid && iss_ready;
    assign sb_set    = issue && iss_dest_en && !is_zero_reg(iss_dest);
    assign sb_clr    = wb_valid && !is_zero_reg(wb_reg);

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (sb_set),
        .set_idx (iss_dest),
        .clr_en  (sb_clr),
        .clr_idx (wb_reg),
        .busy    (busy)
    );

    always_comb begin
        op_valid_d   = op_valid_q;
        op_val_a_d   = op_val_a_q;
        op_val_b_d   = op_val_b_q;
        op_dest_d    = op_dest_q;
        op_dest_en_d = op_dest_en_q;
        wb_err_d     = wb_err_q;
        stall_d      = stall_q;

        if (issue) begin
            op_valid_d   = 1'b1;
            op_dest_d    = iss_dest;
            op_dest_en_d = iss_dest_en;
            if (is_zero_reg(iss_regA)) begin
                op_val_a_d = '0;
            end else if (wb_hit_a) begin
                op_val_a_d = wb_value;
            end else begin
                op_val_a_d = rf_valA;
            end
            if (is_zero_reg(iss_regB)) begin
                op_val_b_d = '0;
            end else if (wb_hit_b) begin
                op_val_b_d = wb_value;
            end else begin
                op_val_b_d = rf_valB;
            end
        end else if (op_valid_q && op_ready) begin
            op_valid_d = 1'b0;
        end

        if (sb_clr && !busy[wb_reg]) begin
            wb_err_d = 1'b1;
        end

        if (iss_valid && !iss_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q   <= 1'b0;
            op_val_a_q   <= '0;
            op_val_b_q   <= '0;
            op_dest_q    <= REG_ZERO;
            op_dest_en_q <= 1'b0;
            wb_err_q     <= 1'b0;
            stall_q      <= '0;
        end else begin
            op_valid_q   <= op_valid_d;
            op_val_a_q   <= op_val_a_d;
            op_val_b_q   <= op_val_b_d;
            op_dest_q    <= op_dest_d;
            op_dest_en_q <= op_dest_en_d;
            wb_err_q     <= wb_err_d;
            stall_q      <= stall_d;
        end
    end

    assign op_valid   = op_valid_q;
    assign op_valA    = op_val_a_q;
    assign op_valB    = op_val_b_q;
    assign op_dest    = op_dest_q;
    assign op_dest_en = op_dest_en_q;
    assign wb_err     = wb_err_q;
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_reg_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid, iss_ready, iss_dest_en;
    logic [2:0]  iss_regA, iss_regB, iss_dest;
    logic [2:0]  rf_read_regA, rf_read_regB, rf_write_reg;
    logic [31:0] rf_valA, rf_valB, rf_write_value;
    logic        rf_write_en;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [31:0] wb_value;
    logic        op_valid, op_ready, op_dest_en, wb_err;
    logic [31:0] op_valA, op_valB;
    logic [2:0]  op_dest;
    logic [15:0] stall_cnt;

    logic [31:0] rf_mem [8];
    assign rf_valA = rf_mem[rf_read_regA];
    assign rf_valB = rf_mem[rf_read_regB];

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    bit          m_busy [8];
    bit          m_op_valid, m_op_dest_en, m_wb_err;
    logic [31:0] m_op_a, m_op_b;
    logic [2:0]  m_op_dest;
    int unsigned m_stall;

    reg_access_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_regA       (iss_regA),
        .iss_regB       (iss_regB),
        .iss_dest       (iss_dest),
        .iss_dest_en    (iss_dest_en),
        .rf_read_regA   (rf_read_regA),
        .rf_read_regB   (rf_read_regB),
        .rf_valA        (rf_valA),
        .rf_valB        (rf_valB),
        .rf_write_reg   (rf_write_reg),
        .rf_write_value (rf_write_value),
        .rf_write_en    (rf_write_en),
        .wb_valid       (wb_valid),
        .wb_reg         (wb_reg),
        .wb_value       (wb_value),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_valA        (op_valA),
        .op_valB        (op_valB),
        .op_dest        (op_dest),
        .op_dest_en     (op_dest_en),
        .wb_err         (wb_err),
        .stall_cnt      (stall_cnt)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_op_valid   = 1'b0;
        m_op_a       = '0;
        m_op_b       = '0;
        m_op_dest    = '0;
        m_op_dest_en = 1'b0;
        m_wb_err     = 1'b0;
        m_stall      = 0;
    endtask

    function automatic bit blocked(input logic [2:0] r);
        return (r != 0) && m_busy[r] && !(wb_valid && wb_reg == r);
    endfunction

    function automatic logic [31:0] src_value(input logic [2:0] r);
        if (r == 0) return 32'h0;
        if (wb_valid && wb_reg == r) return wb_value;
        return rf_mem[r];
    endfunction

    // Compare process: check at the falling edge, then advance the model
    // to the state the DUT reaches at the following rising edge.
    initial begin
        bit exp_ready;
        model_reset();
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                continue;
            end
            exp_ready = !blocked(iss_regA) && !blocked(iss_regB)
                        && !(iss_dest_en && blocked(iss_dest))
                        && (!m_op_valid || op_ready);
            check("iss_ready", iss_ready, exp_ready);
            check("rf_read_regA", rf_read_regA, iss_regA);
            check("rf_read_regB", rf_read_regB, iss_regB);
            check("rf_write_reg", rf_write_reg, wb_reg);
            check("rf_write_value", rf_write_value, wb_value);
            check("rf_write_en", rf_write_en, wb_valid && wb_reg != 0);
            check("op_valid", op_valid, m_op_valid);
            if (m_op_valid) begin
                check("op_valA", op_valA, m_op_a);
                check("op_valB", op_valB, m_op_b);
                check("op_dest", op_dest, m_op_dest);
                check("op_dest_en", op_dest_en, m_op_dest_en);
            end
            check("wb_err", wb_err, m_wb_err);
            check("stall_cnt", stall_cnt, m_stall[15:0]);

            if (iss_valid && !exp_ready && m_stall < 32'hFFFF) m_stall++;
            if (wb_valid && wb_reg != 0) begin
                if (!m_busy[wb_reg]) m_wb_err = 1'b1;
                m_busy[wb_reg] = 1'b0;
            end
            if (iss_valid && exp_ready) begin
                m_op_valid   = 1'b1;
                m_op_a       = src_value(iss_regA);
                m_op_b       = src_value(iss_regB);
                m_op_dest    = iss_dest;
                m_op_dest_en = iss_dest_en;
                if (iss_dest_en && iss_dest != 0) m_busy[iss_dest] = 1'b1;
            end else if (m_op_valid && op_ready) begin
                m_op_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] d,
                         input logic de);
        iss_valid   = 1'b1;
        iss_regA    = a;
        iss_regB    = b;
        iss_dest    = d;
        iss_dest_en = de;
    endtask

    task automatic wb(input logic v, input logic [2:0] r, input logic [31:0] val);
        wb_valid = v;
        wb_reg   = r;
        wb_value = val;
    endtask

    initial begin
        int busy_list [$];
        rst_n = 1'b0;
        issue(3'd0, 3'd0, 3'd0, 1'b0);
        iss_valid = 1'b0;
        wb(1'b0, 3'd0, 32'h0);
        op_ready = 1'b1;
        for (int i = 0; i < 8; i++) rf_mem[i] = 32'h11 * i;
        rf_mem[0] = 32'hFF;
        rf_mem[3] = 32'h33;
        step();
        step();
        #2 rst_n = 1'b1;

        // Reset state and register-0 reads.
        step();
        check("reset_op_valid", op_valid, 1'b0);
        check("reset_stall_cnt", stall_cnt, 16'd0);
        check("reset_wb_err", wb_err, 1'b0);
        issue(3'd0, 3'd3, 3'd1, 1'b0);
        step();
        check("zero_op_valid", op_valid, 1'b1);
        check("zero_op_valA", op_valA, 32'h0);
        check("zero_op_valB", op_valB, 32'h33);

        // RAW stall, then release by a bypassed writeback.
        issue(3'd0, 3'd0, 3'd2, 1'b1);
        step();
        issue(3'd2, 3'd0, 3'd0, 1'b0);
        rf_mem[2] = 32'hDEAD;
        #1 check("raw_iss_ready", iss_ready, 1'b0);
        for (int i = 0; i < 3; i++) step();
        check("raw_stall_cnt", stall_cnt, 16'd3);
        wb(1'b1, 3'd2, 32'h1234);
        #1 check("raw_release_ready", iss_ready, 1'b1);
        check("raw_release_wen", rf_write_en, 1'b1);
        step();
        check("bypass_op_valA", op_valA, 32'h1234);
        wb(1'b0, 3'd0, 32'h0);

        // Backpressure holds the bundle, then back-to-back issue on release.
        op_ready = 1'b0;
        issue(3'd3, 3'd0, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_iss_ready", iss_ready, 1'b0);
            step();
            check("bp_op_valA_hold", op_valA, 32'h1234);
        end
        op_ready = 1'b1;
        #1 check("bp_release_ready", iss_ready, 1'b1);
        step();
        check("bp_new_op_valid", op_valid, 1'b1);
        check("bp_new_op_valA", op_valA, 32'h33);
        check("bp_stall_cnt", stall_cnt, 16'd8);

        // WAW resolved by same-cycle writeback; busy stays set.
        issue(3'd0, 3'd0, 3'd5, 1'b1);
        step();
        wb(1'b1, 3'd5, 32'h55);
        #1 check("waw_wb_ready", iss_ready, 1'b1);
        step();
        issue(3'd5, 3'd0, 3'd0, 1'b0);
        wb(1'b0, 3'd0, 32'h0);
        #1 check("waw_busy_kept", iss_ready, 1'b0);
        step();
        wb(1'b1, 3'd5, 32'h5555);
        step();
        check("waw_second_wb_val", op_valA, 32'h5555);
        check("waw_no_err", wb_err, 1'b0);

        // Writeback corner cases.
        iss_valid = 1'b0;
        wb(1'b1, 3'd0, 32'h99);
        #1 check("wb_zero_wen", rf_write_en, 1'b0);
        step();
        wb(1'b1, 3'd4, 32'h7);
        #1 check("wb_idle_wen", rf_write_en, 1'b1);
        step();
        check("wb_err_set", wb_err, 1'b1);
        wb(1'b0, 3'd0, 32'h0);
        step();
        check("wb_err_sticky", wb_err, 1'b1);

        // Asynchronous reset in the middle of activity.
        issue(3'd0, 3'd0, 3'd1, 1'b1);
        step();
        issue(3'd0, 3'd0, 3'd6, 1'b1);
        step();
        check("mid_op_valid", op_valid, 1'b1);
        issue(3'd1, 3'd6, 3'd0, 1'b0);
        #1 check("mid_raw_ready", iss_ready, 1'b0);
        #1 rst_n = 1'b0;
        #1 check("async_op_valid", op_valid, 1'b0);
        check("async_stall_cnt", stall_cnt, 16'd0);
        check("async_wb_err", wb_err, 1'b0);
        #2 rst_n = 1'b1;
        #1 check("post_rst_ready", iss_ready, 1'b1);
        step();
        check("post_rst_op_valid", op_valid, 1'b1);
        check("post_rst_op_valA", op_valA, 32'h11);
        check("post_rst_op_valB", op_valB, 32'h66);

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 8; i++) rf_mem[i] = $urandom;
            iss_valid   = ($urandom_range(0, 3) != 0);
            iss_regA    = 3'($urandom_range(0, 7));
            iss_regB    = 3'($urandom_range(0, 7));
            iss_dest    = 3'($urandom_range(0, 7));
            iss_dest_en = ($urandom_range(0, 3) != 0);
            op_ready    = ($urandom_range(0, 9) < 7);
            busy_list.delete();
            for (int i = 1; i < 8; i++) if (m_busy[i]) busy_list.push_back(i);
            wb_valid = ($urandom_range(0, 9) < 4);
            wb_value = $urandom;
            if (busy_list.size() > 0 && $urandom_range(0, 9) < 8)
                wb_reg = 3'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            else
                wb_reg = 3'($urandom_range(0, 7));
            step();
        end

        iss_valid = 1'b0;
        wb_valid  = 1'b0;
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
Requester-side controller for the LC2K register file: drives its read addresses, write address/value and write enable. Accepts decoded instructions (regA, regB, dest) over a valid/ready handshake and returns registered operands to the execute stage. Takes writebacks from the back end and forwards them to the register file. Tracks pending destinations in a scoreboard, stalls RAW/WAW hazards and bypasses same-cycle writebacks.

Parameters:
DATA_W, 32, register/operand width
NUM_REGS, 8, architectural registers
ADDR_W, 3, register index width (log2 NUM_REGS)
STALL_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
iss_valid  in  1  decoded instruction present
iss_ready  out  1  instruction accepted this cycle when high with iss_valid
iss_regA  in  ADDR_W  source A index
iss_regB  in  ADDR_W  source B index
iss_dest  in  ADDR_W  destination index
iss_dest_en  in  1  instruction writes iss_dest
rf_read_regA  out  ADDR_W  register file read address A
rf_read_regB  out  ADDR_W  register file read address B
rf_valA  in  DATA_W  register file read data A (combinational)
rf_valB  in  DATA_W  register file read data B (combinational)
rf_write_reg  out  ADDR_W  register file write address
rf_write_value  out  DATA_W  register file write data
rf_write_en  out  1  register file write enable
wb_valid  in  1  writeback request (always accepted)
wb_reg  in  ADDR_W  writeback destination
wb_value  in  DATA_W  writeback data
op_valid  out  1  operand bundle valid
op_ready  in  1  execute stage accepts bundle
op_valA  out  DATA_W  operand A
op_valB  out  DATA_W  operand B
op_dest  out  ADDR_W  destination index
op_dest_en  out  1  destination write flag
wb_err  out  1  sticky: writeback to non-busy register
stall_cnt  out  STALL_W  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_n=0): busy[] all 0; op_valid, op_valA, op_valB, op_dest, op_dest_en, wb_err, stall_cnt = 0. Any buffered bundle and all pending scoreboard state are discarded.
- Register 0 always reads 0:
  - Operand reads of index 0 return 0 regardless of rf_val*.
  - Writebacks to 0 keep rf_write_en=0.
  - Dest 0 is never marked busy.
- Register file drive (combinational):
  - rf_read_regA/B = iss_regA/B.
  - rf_write_reg = wb_reg; rf_write_value = wb_value; rf_write_en = wb_valid && wb_reg!=0.
- Hazard conditions:
  - RAW: source s (nonzero) is blocked if busy[s] && !(wb_valid && wb_reg==s).
  - WAW: dest is blocked if iss_dest_en && iss_dest!=0 && busy[iss_dest] && !(wb_valid && wb_reg==iss_dest).
- iss_ready = no RAW on A, no RAW on B, no WAW, and (!op_valid || op_ready). iss_ready must not depend on iss_valid.
- Issue handshake (iss_valid && iss_ready), next edge:
  - op_valid<=1.
  - op_valA/B <= wb_value if wb_valid && wb_reg==src && src!=0 (bypass), else 0 if src==0, else rf_valA/B.
  - op_dest/op_dest_en latched.
  - busy[iss_dest]<=1 if iss_dest_en && iss_dest!=0.
- Latency: 1 cycle from handshake to op_valid. Throughput: 1 instruction/cycle while op_ready=1 and there are no hazards.
- Output buffer:
  - op_valid && op_ready with no new issue: op_valid<=0.
  - op_valid && !op_ready: all op_* hold stable.
- Writeback (wb_valid, wb_reg!=0): busy[wb_reg]<=0.
  - Same-cycle issue setting the same register wins: busy stays 1.
  - If busy[wb_reg] was already 0: write still performed and wb_err<=1 (sticky until reset).
- stall_cnt increments on each cycle with iss_valid && !iss_ready and saturates at all-ones.

Decomposition:
- Shared package lc2k_pkg holds DATA_W, ADDR_W, NUM_REGS, REG_ZERO (3'd0) and the reg_idx_t/word_t typedefs. The same package is used by the register file and the decoder.
- One sub-module, reg_scoreboard:
  - Inputs: set_en/set_idx, clr_en/clr_idx.
  - Output: busy vector.
  - Async active-low reset; set has priority over clear on the same index.

Test Plan:
- Reset and zero reg: release rst_n; issue regA=0, regB=3 with rf_valB=0x33 and rf_valA=0xFF -> next cycle op_valid=1, op_valA=0, op_valB=0x33; stall_cnt=0, wb_err=0.
- RAW stall and release:
  - Issue dest=2 (dest_en=1), then issue regA=2 -> iss_ready=0; stall_cnt counts 3 over 3 cycles.
  - wb_valid wb_reg=2 wb_value=0x1234 in cycle 4 -> that cycle iss_ready=1, rf_write_en=1, and op_valA=0x1234 (bypass), not rf_valA.
- Backpressure: hold op_ready=0 with op_valid=1 -> iss_ready=0 and op_* stable for 5 cycles; raise op_ready with a new issue pending -> new bundle the next cycle, no gap.
- WAW plus simultaneous set/clear:
  - busy[5]=1; issue dest=5 while wb_reg=5 in the same cycle -> accepted and busy[5] remains 1.
  - A later read of 5 stalls until a second writeback to 5.
- Writeback corner cases:
  - wb_reg=0 value 0x99 -> rf_write_en=0, busy unchanged.
  - wb_reg=4 while not busy -> rf_write_en=1 and wb_err=1, sticky.
- Mid-operation reset: with busy[1,6]=1 and op_valid=1, pulse rst_n low asynchronously (not clock-aligned) -> op_valid=0 immediately; after release, issue regA=1 is accepted in the first cycle.
